// File: rtl/booth_sched_pkg.sv
// -----------------------------------------------------------------------------
// booth_sched_pkg
// Shared types and widths for the shared Booth multiplier scheduler.
//   sched_state_t : scheduler FSM states (IDLE, CALC, RESP)
//   OPW           : operand width (signed)
//   RESW          : product width (signed)
// -----------------------------------------------------------------------------
package booth_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int OPW  = 16;
  localparam int RESW = 32;

endpackage

// File: rtl/booth_rr_arb.sv
// -----------------------------------------------------------------------------
// booth_rr_arb
// Combinational round-robin arbiter. The search begins one position after
// the last winner and wraps modulo NREQ; the pointer register is owned by
// the caller.
// Ports:
//   req   : request vector (NREQ)
//   last  : index of the previous winner
//   grant : one-hot grant (all zero when no request)
//   gidx  : encoded index of the granted requester
// -----------------------------------------------------------------------------
module booth_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/boothmul.sv
// -----------------------------------------------------------------------------
// boothmul
// Combinational signed OPW x OPW -> RESW radix-4 Booth multiplier.
// Ports:
//   num : signed multiplicand
//   mul : signed multiplier
//   ans : signed exact product num*mul
// -----------------------------------------------------------------------------
module boothmul
  import booth_sched_pkg::*;
(
  input  logic signed [OPW-1:0]  num,
  input  logic signed [OPW-1:0]  mul,
  output logic signed [RESW-1:0] ans
);

  // Multiplier with an implicit zero below the LSB, so every digit sees a
  // full overlapping 3-bit window.
  logic [OPW:0]           mul_ext;
  logic signed [RESW-1:0] num_ext;
  logic signed [RESW-1:0] pp;
  logic signed [RESW-1:0] acc;

  assign mul_ext = {mul, 1'b0};

  always_comb begin
    num_ext = {{(RESW-OPW){num[OPW-1]}}, num};
    pp      = '0;
    acc     = '0;
    for (int i = 0; i < OPW/2; i++) begin
      // Digit in {-2,-1,0,+1,+2}; the -2*num case for num=-32768 still fits
      // comfortably inside RESW bits.
      case (mul_ext[2*i +: 3])
        3'b001, 3'b010: pp = num_ext;
        3'b011:         pp = num_ext <<< 1;
        3'b100:         pp = -(num_ext <<< 1);
        3'b101, 3'b110: pp = -num_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
    ans = acc;
  end

endmodule

// File: rtl/booth_mul_sched.sv
// -----------------------------------------------------------------------------
// booth_mul_sched
// Round-robin scheduler sharing one combinational Booth multiplier between
// NREQ requesters, with registers on both sides of the multiplier.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_valid   : per-requester operand valid (NREQ)
//   req_ready   : per-requester accept, at most one bit high (NREQ)
//   req_num     : multiplicands, slice i = [16i+15:16i]
//   req_mul     : multipliers, same slicing
//   rsp_valid   : product available (held until rsp_ready)
//   rsp_ready   : consumer accepts the product
//   rsp_id      : requester index owning the product
//   rsp_ans     : signed 32-bit product
//   busy        : high whenever the scheduler is not idle
//   op_count    : completed response count (only with
//                 BOOTH_MUL_SCHED_STATS_EN defined)
// -----------------------------------------------------------------------------
module booth_mul_sched
  import booth_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_num,
  input  logic [NREQ*OPW-1:0] req_mul,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [RESW-1:0]     rsp_ans,
  output logic                busy
`ifdef BOOTH_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]         op_count
`endif
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  sched_state_t           state;
  logic [IDW-1:0]         last;
  logic [NREQ-1:0]        grant;
  logic [IDW-1:0]         gidx;
  logic                   req_hs;
  logic                   rsp_hs;
  logic signed [OPW-1:0]  sel_num;
  logic signed [OPW-1:0]  sel_mul;
  logic signed [OPW-1:0]  num_p0;
  logic signed [OPW-1:0]  mul_p0;
  logic [IDW-1:0]         id_p0;
  logic signed [RESW-1:0] prod_p1;

  booth_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (grant),
    .gidx  (gidx)
  );

  // The reset gate keeps req_ready low while rst_n is asserted even though
  // the state register already reads IDLE at that point.
  assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;
  assign req_hs    = |(req_valid & req_ready);
  assign rsp_hs    = rsp_valid & rsp_ready;

  assign sel_num = req_num[int'(gidx)*OPW +: OPW];
  assign sel_mul = req_mul[int'(gidx)*OPW +: OPW];

  // Stage p0: operand capture; contents only matter once the FSM is in CALC
  always_ff @(posedge clk) begin
    if (req_hs) begin
      num_p0 <= sel_num;
      mul_p0 <= sel_mul;
      id_p0  <= gidx;
    end
  end

  // Stage p1: combinational multiply between the operand and result registers
  boothmul u_mul (
    .num (num_p0),
    .mul (mul_p0),
    .ans (prod_p1)
  );

  // Stage p2: result register and scheduler FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= LAST_RST;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_ans   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            last  <= gidx;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rsp_ans   <= prod_p1;
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef BOOTH_MUL_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_hs) begin
      op_count <= op_count + 32'd1;
    end
  end
`else
  logic unused_rsp_hs;
  assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
module tb_booth_mul_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_num;
  logic [NREQ*16-1:0] req_mul;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_ans;
  logic              busy;
`ifdef BOOTH_MUL_SCHED_STATS_EN
  logic [31:0]       op_count;
`endif

  always #5 clk = ~clk;

  booth_mul_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_num   (req_num),
    .req_mul   (req_mul),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_ans   (rsp_ans),
    .busy      (busy)
`ifdef BOOTH_MUL_SCHED_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int last_m;
  int ops_m;
  int g;
  logic [15:0] tnum [NREQ];
  logic [15:0] tmul [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first valid requester after the previous winner.
  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last_m + k) % NREQ;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_num[16*i +: 16] = tnum[i];
      req_mul[16*i +: 16] = tmul[i];
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa, sb;
    logic signed [31:0] p;
    sa = a;
    sb = b;
    p  = sa * sb;
    return p;
  endfunction

  // One full operation, started in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_op(input logic [NREQ-1:0] vmask, input int hold, output int gw);
    logic [31:0] e;
    drive_ops();
    req_valid = vmask;
    rsp_ready = 1'b0;
    #1;
    gw = pick(vmask);
    chk("grant", req_ready, 64'd1 << gw);
    e = ref_prod(tnum[gw], tmul[gw]);
    tick();
    last_m = gw;
    chk("calc_busy", busy, 1);
    chk("calc_rsp_valid", rsp_valid, 0);
    chk("calc_req_ready", req_ready, 0);
    tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_ans", rsp_ans, e);
    chk("rsp_id", rsp_id, gw);
    for (int c = 0; c < hold; c++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ans", rsp_ans, e);
      chk("bp_id", rsp_id, gw);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick();
    ops_m++;
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_num   = '0;
    req_mul   = '0;
    last_m    = NREQ - 1;
    ops_m     = 0;
    for (int i = 0; i < NREQ; i++) begin
      tnum[i] = 16'(i + 1);
      tmul[i] = 16'(i + 7);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_ans", rsp_ans, 0);
    chk("rst_busy", busy, 0);
`ifdef BOOTH_MUL_SCHED_STATS_EN
    chk("rst_op_count", op_count, 0);
`endif
    rst_n = 1'b1;

    // Fairness: all requesters valid, back-to-back ops -> 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        tnum[r] = 16'($urandom);
        tmul[r] = 16'($urandom);
      end
      run_op('1, 0, g);
      chk("fair_order", g, i % NREQ);
    end

    // Single op on requester 0
    tnum[0] = 16'd3;
    tmul[0] = 16'hFFFB;
    run_op(4'b0001, 0, g);

    // Corners
    tnum[1] = 16'h8000; tmul[1] = 16'h8000;
    run_op(4'b0010, 0, g);
    tnum[3] = 16'h7FFF; tmul[3] = 16'h8000;
    run_op(4'b1000, 0, g);
    tnum[2] = 16'h8000; tmul[2] = 16'h7FFF;
    run_op(4'b0100, 0, g);

    // Backpressure for 5 cycles with all others requesting
    tnum[1] = 16'h1234; tmul[1] = 16'hF00D;
    run_op(4'b1111, 5, g);

    // Valid dropped before handshake leaves no trace
    req_valid = 4'b1111;
    #1;
    chk("drop_grant", req_ready, 64'd1 << pick(4'b1111));
    req_valid = '0;
    tick();
    chk("drop_busy", busy, 0);
    chk("drop_rsp_valid", rsp_valid, 0);
    run_op(4'b1111, 1, g);

    // Reset during CALC
    tnum[2] = 16'd100; tmul[2] = 16'd200;
    drive_ops();
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", req_ready, 64'd1 << 2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ans", rsp_ans, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    req_valid = '0;
    tick();
    tick();
    rst_n  = 1'b1;
    last_m = NREQ - 1;
    ops_m  = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_valid", rsp_valid, 0);
    end
    run_op(4'b1111, 0, g);
    chk("post_rst_first", g, 0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        tnum[r] = 16'($urandom);
        tmul[r] = 16'($urandom);
      end
      run_op(m, int'($urandom_range(0, 2)), g);
    end

`ifdef BOOTH_MUL_SCHED_STATS_EN
    chk("op_count", op_count, ops_m);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
